io16_spi_slave: RTL and testbench

IO16_SPI_SLAVE -- requirements
Module: io16_spi_slave

---
 rtl/io16_pkg.sv | 12 +
 rtl/io16_sync.sv | 24 ++
 rtl/io16_spi_slave.sv | 156 +++++++++++++++
 tb/tb_io16_spi_slave.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/io16_pkg.sv
// Shared constants and FSM state encoding for the io16 SPI slave.
package io16_pkg;

    localparam int                   IO16_BYTE_W    = 8;
    localparam logic [IO16_BYTE_W-1:0] IO16_IDLE_FILL = 8'hFF;

    typedef enum logic {
        IO16_IDLE  = 1'b0,
        IO16_SHIFT = 1'b1
    } io16_state_e;

endpackage

// File: rtl/io16_sync.sv
// Single-bit synchronizer of configurable depth with a selectable reset level.
module io16_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/io16_spi_slave.sv
// Mode-0 SPI slave with byte handshakes on the system clock.
// Optional interrupt output enabled by defining IO16_SPI_INT_EN.
module io16_spi_slave
    import io16_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   IO16_CLK,
    input  logic                   IO16_RST,
    input  logic                   IO16_SPI_CLK_IN,
    input  logic                   IO16_SPI_MOSI_IN,
    input  logic                   IO16_SPI_NSS_IN,
    output logic                   IO16_SPI_MISO_OUT,
    output logic                   IO16_SPI_MISO_OE,
    output logic                   IO16_SPI_INT_OUT,
    output logic [IO16_BYTE_W-1:0] IO16_RX_DATA,
    output logic                   IO16_RX_VALID,
    input  logic                   IO16_RX_READY,
    output logic                   IO16_RX_OVERRUN,
    input  logic [IO16_BYTE_W-1:0] IO16_TX_DATA,
    input  logic                   IO16_TX_VALID,
    output logic                   IO16_TX_READY
);

    localparam int         FLUSH    = SYNC_STAGES + 1;
    localparam logic [2:0] LAST_BIT = 3'(IO16_BYTE_W - 1);

    logic sck_s, mosi_s, nss_s;

    io16_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk_i(IO16_CLK), .rst_i(IO16_RST), .d_i(IO16_SPI_CLK_IN),  .q_o(sck_s)
    );
    io16_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(IO16_CLK), .rst_i(IO16_RST), .d_i(IO16_SPI_MOSI_IN), .q_o(mosi_s)
    );
    io16_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nss (
        .clk_i(IO16_CLK), .rst_i(IO16_RST), .d_i(IO16_SPI_NSS_IN),  .q_o(nss_s)
    );

    io16_state_e            state_q;
    logic [2:0]             flush_q;
    logic                   sck_prev_q, nss_prev_q;
    logic [2:0]             bit_cnt_q;
    logic [IO16_BYTE_W-1:0] rx_sh_q, tx_sh_q, rx_data_q;
    logic                   rx_valid_q, rx_ovr_q, tx_ready_q, miso_oe_q, done_q;

    logic                   live, sck_rise, sck_fall, nss_rise, nss_fall;
    logic [IO16_BYTE_W-1:0] tx_load;

    // Edges are ignored until the synchronizers hold real pin levels, so a
    // reset released while NSS is low cannot fake a chip-select fall.
    assign live     = (flush_q == 3'(FLUSH));
    assign sck_rise = live &  sck_s & ~sck_prev_q;
    assign sck_fall = live & ~sck_s &  sck_prev_q;
    assign nss_rise = live &  nss_s & ~nss_prev_q;
    assign nss_fall = live & ~nss_s &  nss_prev_q;
    assign tx_load  = IO16_TX_VALID ? IO16_TX_DATA : IO16_IDLE_FILL;

    always_ff @(posedge IO16_CLK or posedge IO16_RST) begin
        if (IO16_RST) begin
            state_q    <= IO16_IDLE;
            flush_q    <= '0;
            sck_prev_q <= 1'b0;
            nss_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            miso_oe_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            nss_prev_q <= nss_s;
            if (!live) flush_q <= flush_q + 3'd1;
            tx_ready_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            done_q     <= 1'b0;

            // A completing byte wins over a same-cycle accept: accept-then-load.
            if (done_q) begin
                if (rx_valid_q && !IO16_RX_READY) begin
                    rx_ovr_q <= 1'b1;
                end else begin
                    rx_data_q  <= rx_sh_q;
                    rx_valid_q <= 1'b1;
                end
            end else if (rx_valid_q && IO16_RX_READY) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IO16_IDLE: begin
                    if (nss_fall) begin
                        state_q    <= IO16_SHIFT;
                        miso_oe_q  <= 1'b1;
                        bit_cnt_q  <= '0;
                        rx_sh_q    <= '0;
                        tx_sh_q    <= tx_load;
                        tx_ready_q <= IO16_TX_VALID;
                    end
                end
                IO16_SHIFT: begin
                    if (nss_rise) begin
                        state_q   <= IO16_IDLE;
                        miso_oe_q <= 1'b0;
                        bit_cnt_q <= '0;
                        rx_sh_q   <= '0;
                    end else begin
                        if (done_q) begin
                            tx_sh_q    <= tx_load;
                            tx_ready_q <= IO16_TX_VALID;
                        end
                        if (sck_rise) begin
                            rx_sh_q   <= {rx_sh_q[IO16_BYTE_W-2:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            done_q    <= (bit_cnt_q == LAST_BIT);
                        end
                        // The fall after a byte boundary must keep the freshly
                        // reloaded MSB on the line, so it does not shift.
                        if (sck_fall && bit_cnt_q != 3'd0) begin
                            tx_sh_q <= {tx_sh_q[IO16_BYTE_W-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IO16_IDLE;
            endcase
        end
    end

    assign IO16_SPI_MISO_OUT = miso_oe_q & tx_sh_q[IO16_BYTE_W-1];
    assign IO16_SPI_MISO_OE  = miso_oe_q;
    assign IO16_RX_DATA      = rx_data_q;
    assign IO16_RX_VALID     = rx_valid_q;
    assign IO16_RX_OVERRUN   = rx_ovr_q;
    assign IO16_TX_READY     = tx_ready_q;

`ifdef IO16_SPI_INT_EN
    logic int_q;

    always_ff @(posedge IO16_CLK or posedge IO16_RST) begin
        if (IO16_RST) begin
            int_q <= 1'b0;
        end else begin
            int_q <= rx_valid_q | ((state_q == IO16_IDLE) & ~IO16_TX_VALID);
        end
    end

    assign IO16_SPI_INT_OUT = int_q;
`else
    assign IO16_SPI_INT_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_io16_spi_slave.sv
// Directed bench for io16_spi_slave: SPI mode-0 master model plus handshake checks.
module tb_io16_spi_slave;

    logic       clk = 1'b0, rst = 1'b1;
    logic       sck = 1'b0, mosi = 1'b0, nss = 1'b1;
    logic       miso, miso_oe, int_out;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b0, rx_ovr;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, tx_ready;

    always #5 clk = ~clk;

    io16_spi_slave #(.SYNC_STAGES(2)) dut (
        .IO16_CLK(clk), .IO16_RST(rst),
        .IO16_SPI_CLK_IN(sck), .IO16_SPI_MOSI_IN(mosi), .IO16_SPI_NSS_IN(nss),
        .IO16_SPI_MISO_OUT(miso), .IO16_SPI_MISO_OE(miso_oe), .IO16_SPI_INT_OUT(int_out),
        .IO16_RX_DATA(rx_data), .IO16_RX_VALID(rx_valid), .IO16_RX_READY(rx_ready),
        .IO16_RX_OVERRUN(rx_ovr), .IO16_TX_DATA(tx_data), .IO16_TX_VALID(tx_valid),
        .IO16_TX_READY(tx_ready)
    );

    int   n_chk = 0, n_err = 0;
    int   n_txr = 0, n_ovr = 0, n_rxv = 0, int_bad = 0;
    logic rxv_prev = 1'b0;

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_ready) n_txr++;
        if (rx_ovr) n_ovr++;
        if (rx_valid && !rxv_prev) n_rxv++;
        rxv_prev = rx_valid;
`ifndef IO16_SPI_INT_EN
        if (int_out !== 1'b0) int_bad++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side: drive MOSI, sample MISO just before each rising SCK.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi  = mo[i];
            clks(8);
            mi[i] = miso;
            sck   = 1'b1;
            clks(8);
            sck   = 1'b0;
        end
        clks(8);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        clks(1);
        rx_ready = 1'b0;
        clks(1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_miso"},  miso,     0);
        chk({pfx, "_oe"},    miso_oe,  0);
        chk({pfx, "_int"},   int_out,  0);
        chk({pfx, "_rxd"},   rx_data,  8'h00);
        chk({pfx, "_rxv"},   rx_valid, 0);
        chk({pfx, "_ovr"},   rx_ovr,   0);
        chk({pfx, "_txr"},   tx_ready, 0);
    endtask

    initial begin
        logic [7:0] mi;
        int         t0, o0, v0;
        bit         found;

        // Reset state
        clks(3);
        chk_reset_outputs("rst");
        rst = 1'b0;
        clks(10);

        // TX A5 while receiving 3C
        tx_data = 8'hA5; tx_valid = 1'b1;
        t0 = n_txr;
        nss = 1'b0;
        clks(10);
        chk("t1_oe", miso_oe, 1);
        chk("t1_txr_load", n_txr - t0, 1);
        tx_valid = 1'b0;
        spi_xfer(8'h3C, 8, mi);
        chk("t1_miso", mi, 8'hA5);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (rx_valid) found = 1'b1;
            else clks(1);
        end
        chk("t1_rxv", found, 1);
        chk("t1_rxd", rx_data, 8'h3C);
        chk("t1_txr_total", n_txr - t0, 1);
        rx_ready = 1'b1;
        clks(1);
        chk("t1_rxv_clr", rx_valid, 0);
        rx_ready = 1'b0;
        clks(1);
        nss = 1'b1;
        clks(10);
        chk("t1_oe_off", miso_oe, 0);

        // TX starved: idle fill on MISO, no TX_READY
        t0 = n_txr;
        nss = 1'b0;
        clks(10);
        spi_xfer(8'h00, 8, mi);
        clks(4);
        chk("t2_miso", mi, 8'hFF);
        chk("t2_rxv", rx_valid, 1);
        chk("t2_rxd", rx_data, 8'h00);
        chk("t2_txr", n_txr - t0, 0);
        nss = 1'b1;
        clks(10);
        accept();

        // Overrun: two bytes with consumer stalled
        o0 = n_ovr;
        nss = 1'b0;
        clks(10);
        spi_xfer(8'h11, 8, mi);
        spi_xfer(8'h22, 8, mi);
        clks(4);
        chk("t3_rxd", rx_data, 8'h11);
        chk("t3_rxv", rx_valid, 1);
        chk("t3_ovr", n_ovr - o0, 1);
        nss = 1'b1;
        clks(10);
        accept();

        // Aborted byte then a clean one
        v0 = n_rxv;
        nss = 1'b0;
        clks(10);
        spi_xfer(8'hFF, 5, mi);
        nss = 1'b1;
        clks(20);
        chk("t4_abort_rxv", n_rxv - v0, 0);
        nss = 1'b0;
        clks(10);
        spi_xfer(8'h81, 8, mi);
        clks(4);
        chk("t4_rxv", n_rxv - v0, 1);
        chk("t4_rxd", rx_data, 8'h81);
        nss = 1'b1;
        clks(10);
        accept();

        // Reset mid-byte, released with NSS still low
        tx_data = 8'hC3; tx_valid = 1'b1;
        nss = 1'b0;
        clks(10);
        tx_valid = 1'b0;
        spi_xfer(8'hF0, 4, mi);
        rst = 1'b1;
        #1;
        chk_reset_outputs("t5");
        clks(3);
        rst = 1'b0;
        v0 = n_rxv;
        clks(10);
        spi_xfer(8'hFF, 8, mi);
        chk("t5_stuck_oe", miso_oe, 0);
        chk("t5_stuck_rxv", n_rxv - v0, 0);
        nss = 1'b1;
        clks(10);
        tx_valid = 1'b1;
        t0 = n_txr;
        nss = 1'b0;
        clks(10);
        tx_valid = 1'b0;
        spi_xfer(8'h5A, 8, mi);
        clks(4);
        chk("t5_miso", mi, 8'hC3);
        chk("t5_rxd", rx_data, 8'h5A);
        chk("t5_txr", n_txr - t0, 1);

        // Interrupt timing relative to RX_VALID and accept
        accept();
        found = 1'b0;
        spi_xfer(8'h77, 8, mi);
        for (int k = 0; k < 20 && !found; k++) begin
            clks(1);
            if (rx_valid) found = 1'b1;
        end
        chk("t6_rxv", found, 1);
`ifdef IO16_SPI_INT_EN
        chk("t6_int_lag", int_out, 0);
        clks(1);
        chk("t6_int_rise", int_out, 1);
        tx_valid = 1'b1;
        rx_ready = 1'b1;
        clks(1);
        rx_ready = 1'b0;
        chk("t6_int_hold", int_out, 1);
        clks(1);
        chk("t6_int_fall", int_out, 0);
        tx_valid = 1'b0;
`else
        accept();
        chk("t6_int_const", int_bad, 0);
`endif
        nss = 1'b1;
        clks(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
